// File: rtl/dbg_pkg.sv
// Shared encodings for the board debug controller: key modes, FSM states
// and the active-low seven-segment glyph table.
package dbg_pkg;

    localparam logic [1:0] MODE_STEP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t S_STEP  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_BURST = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index = nibble value; bits[6:0] = g..a, bit 7 (dp) kept off.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// One seven-segment digit: nibble to active-low segments, with optional
// decimal point and a blank override.
module hex_to_seg7
    import dbg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        if (blank_i) seg_o = SEG_BLANK;
        else         seg_o = {~dp_i, SEG_TABLE[nib_i][6:0]};
    end

endmodule

// File: rtl/board_debug_ctrl.sv
// Board debug controller: debounced step / free-run / burst clock-enable for
// the core, a step counter, and a paged probe display on HEX0..5 and LEDR.
module board_debug_ctrl
    import dbg_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 5000000,
    parameter int BURST_LEN       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_key,
    input  logic [1:0]            mode,
    input  logic [3:0]            ch_sel,
    input  logic                  page,
    input  logic [NUM_CH*32-1:0]  ch_data,
    output logic                  cpu_clk_en,
    output logic [31:0]           step_count,
    output logic [47:0]           hex,
    output logic [9:0]            ledr
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV + 1);
    localparam int BST_W = $clog2(BURST_LEN + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [BST_W-1:0] BST_LOAD = BST_W'(BURST_LEN);

    logic             key_s1_q, key_s2_q;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BST_W-1:0] burst_q, burst_d;
    logic             en_q, en_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [47:0]      hex_q, hex_d;
    logic [9:0]       ledr_q, ledr_d;
    logic             deb_mis, deb_done, press;
    logic [31:0]      sel_val;

    // Key is idle-high, so the synchroniser and accepted level reset to 1.
    always_comb begin
        deb_mis   = key_s2_q != deb_q;
        deb_done  = deb_mis && (deb_cnt_q == DEB_LAST);
        deb_cnt_d = (deb_mis && !deb_done) ? deb_cnt_q + DEB_W'(1) : '0;
        deb_d     = deb_done ? key_s2_q : deb_q;
        press     = deb_done && deb_q;
    end

    always_comb begin
        case (mode)
            MODE_RUN:   state_d = S_RUN;
            MODE_BURST: state_d = S_BURST;
            default:    state_d = S_STEP;
        endcase
    end

    always_comb begin
        div_d   = div_q;
        burst_d = burst_q;
        en_d    = 1'b0;
        if (state_q != state_d) begin
            // Mode switch: drop any partial divide or burst in flight.
            div_d   = '0;
            burst_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (div_q == DIV_LAST) begin
                        en_d  = 1'b1;
                        div_d = '0;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_BURST: begin
                    if (burst_q == '0) begin
                        if (press) begin
                            burst_d = BST_LOAD;
                            div_d   = '0;
                        end
                    end else if (div_q == DIV_LAST) begin
                        en_d    = 1'b1;
                        div_d   = '0;
                        burst_d = burst_q - BST_W'(1);
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: begin
                    div_d = '0;
                    en_d  = press;
                end
            endcase
        end
        cnt_d = cnt_q + 32'(en_q);
    end

    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch_sel == 4'(k)) sel_val = ch_data[32*k +: 32];
        ledr_d = sel_val[9:0];
    end

    for (genvar k = 0; k < 6; k++) begin : g_dig
        localparam int HI_LSB = (k < 2) ? 24 + 4*k : 24;
        logic [3:0] nib;
        logic       dp, blank;

        always_comb begin
            nib   = sel_val[4*k +: 4];
            dp    = 1'b0;
            blank = 1'b0;
            if (page) begin
                if (k < 2)       nib   = sel_val[HI_LSB +: 4];
                else if (k == 5) nib   = ch_sel;
                else             blank = 1'b1;
                dp = (k == 0);
            end
        end

        hex_to_seg7 u_seg (
            .nib_i   (nib),
            .dp_i    (dp),
            .blank_i (blank),
            .seg_o   (hex_d[8*k +: 8])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1_q  <= 1'b1;
            key_s2_q  <= 1'b1;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
            state_q   <= S_STEP;
            div_q     <= '0;
            burst_q   <= '0;
            en_q      <= 1'b0;
            cnt_q     <= '0;
            hex_q     <= {6{SEG_BLANK}};
            ledr_q    <= '0;
        end else begin
            key_s1_q  <= step_key;
            key_s2_q  <= key_s1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            div_q     <= div_d;
            burst_q   <= burst_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            hex_q     <= hex_d;
            ledr_q    <= ledr_d;
        end
    end

    assign cpu_clk_en = en_q;
    assign step_count = cnt_q;
    assign hex        = hex_q;
    assign ledr       = ledr_q;

endmodule
